// File: rtl/graha_power_sequencer_if.sv
// Target-mask request channel between the PMU firmware side and the power sequencer.
// Handshake: a mask transfers on a clock edge where req_valid && req_ready; the master holds req_mask stable while req_valid is high.
interface graha_power_sequencer_if;
    logic       req_valid;
    logic [8:0] req_mask;
    logic       req_ready;

    modport master (output req_valid, output req_mask, input req_ready);
    modport slave  (input req_valid, input req_mask, output req_ready);
endinterface

// File: rtl/graha_power_sequencer.sv
// Nava Graha power-domain sequencer: walks domain_en toward a requested mask one domain at a time.
// Optional GRAHA_SEQ_EMERGENCY_EN adds emerg_off, which forces the retention set and returns to IDLE.
module graha_power_sequencer #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic                          clk,
    input  logic                          rst_n,
    graha_power_sequencer_if.slave        req,
    input  logic [8:0]                    domain_pg,
    output logic [8:0]                    domain_en,
    output logic                          busy,
    output logic                          done,
    output logic                          fault,
    output logic [3:0]                    fault_domain,
    input  logic                          fault_clear,
`ifdef GRAHA_SEQ_EMERGENCY_EN
    input  logic                          emerg_off,
`endif
    output logic [2:0]                    state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SCAN       = 3'd1,
        S_DOWN_WAIT  = 3'd2,
        S_UP_WAIT_PG = 3'd3,
        S_UP_SETTLE  = 3'd4,
        S_FAULT      = 3'd5
    } state_t;

    localparam logic [8:0] RESET_EN  = 9'h1C0;
    localparam logic [8:0] FORCED_ON = 9'h180;
    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [8:0] en_q, en_d;
    logic [8:0] tgt_q, tgt_d;
    logic [3:0] cur_q, cur_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fault_q, fault_d;
    logic [3:0] fdom_q, fdom_d;
    logic       done_c;

    logic [8:0] off_set, on_set, req_tgt;
    logic [3:0] off_hi, on_lo;

    assign off_set = en_q & ~tgt_q;
    assign on_set  = tgt_q & ~en_q;

    // Power-down picks the highest index, power-up the lowest.
    always_comb begin
        off_hi = 4'd0;
        on_lo  = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (off_set[i]) off_hi = 4'(i);
        end
        for (int i = 8; i >= 0; i--) begin
            if (on_set[i]) on_lo = 4'(i);
        end
    end

    // Mangala cannot be powered without Surya, so drop it from the target instead.
    always_comb begin
        req_tgt = req.req_mask | FORCED_ON;
        if (req_tgt[2] && !req_tgt[0]) req_tgt[2] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        tgt_d   = tgt_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        fdom_d  = fdom_q;
        done_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req.req_valid) begin
                    tgt_d   = req_tgt;
                    cnt_d   = 8'd0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                cnt_d = 8'd0;
                if (|off_set) begin
                    en_d[off_hi] = 1'b0;
                    state_d      = S_DOWN_WAIT;
                end else if (|on_set) begin
                    en_d[on_lo] = 1'b1;
                    cur_d       = on_lo;
                    state_d     = S_UP_WAIT_PG;
                end else begin
                    done_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DOWN_WAIT: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_SCAN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_UP_WAIT_PG: begin
                if (domain_pg[cur_q]) begin
                    cnt_d   = 8'd0;
                    state_d = S_UP_SETTLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    en_d[cur_q] = 1'b0;
                    fault_d     = 1'b1;
                    fdom_d      = cur_q;
                    cnt_d       = 8'd0;
                    state_d     = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_UP_SETTLE: begin
                // A power-good drop restarts the full timeout window.
                if (!domain_pg[cur_q]) begin
                    cnt_d   = 8'd0;
                    state_d = S_UP_WAIT_PG;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_SCAN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_FAULT: begin
                if (fault_clear) begin
                    fault_d = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef GRAHA_SEQ_EMERGENCY_EN
        if (emerg_off) begin
            en_d    = RESET_EN;
            cnt_d   = 8'd0;
            fault_d = fault_q;
            state_d = S_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            en_q    <= RESET_EN;
            tgt_q   <= FORCED_ON;
            cur_q   <= 4'd0;
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
            fdom_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            fdom_q  <= fdom_d;
        end
    end

    assign req.req_ready = (state_q == S_IDLE);
    assign busy          = (state_q == S_SCAN) || (state_q == S_DOWN_WAIT) ||
                           (state_q == S_UP_WAIT_PG) || (state_q == S_UP_SETTLE);
    assign done          = done_c;
    assign domain_en     = en_q;
    assign fault         = fault_q;
    assign fault_domain  = fdom_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_graha_power_sequencer.sv
// Directed bench for graha_power_sequencer: ramps, ordering, Mangala rule, timeout fault, ignored requests, reset.
module tb_graha_power_sequencer;

    localparam int S    = 16;
    localparam int T    = 200;
    // Regulator model: power-good reaches the sequencer on the third cycle of an enable.
    localparam int STEP = 3 + S + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] domain_pg;
    logic [8:0] domain_en;
    logic       busy, done, fault, fault_clear;
    logic [3:0] fault_domain;
    logic [2:0] state_dbg;
`ifdef GRAHA_SEQ_EMERGENCY_EN
    logic       emerg_off = 1'b0;
`endif

    graha_power_sequencer_if rq ();

    graha_power_sequencer #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (rq.slave),
        .domain_pg    (domain_pg),
        .domain_en    (domain_en),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .fault_domain (fault_domain),
        .fault_clear  (fault_clear),
`ifdef GRAHA_SEQ_EMERGENCY_EN
        .emerg_off    (emerg_off),
`endif
        .state_dbg    (state_dbg)
    );

    // clock / reset / regulator model
    always #5 clk = ~clk;

    int         cyc = 0;
    logic [8:0] pg_p1 = 9'h0, pg_p2 = 9'h0, pg_block = 9'h0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pg_p1 <= domain_en;
        pg_p2 <= pg_p1;
    end
    assign domain_pg = pg_p2 & ~pg_block;

    int total = 0;
    int bad   = 0;

    // observation records filled by run_watch
    int rise_cyc [9];
    int fall_cyc [9];
    int done_cnt, done_cyc, fault_cyc, acc;

    task automatic send_req(input logic [8:0] m);
        @(negedge clk);
        rq.req_valid = 1'b1;
        rq.req_mask  = m;
        acc          = cyc;
        @(posedge clk);
        #1;
        rq.req_valid = 1'b0;
    endtask

    task automatic run_watch(input int n);
        logic [8:0] prev;
        prev = domain_en;
        for (int i = 0; i < 9; i++) begin
            rise_cyc[i] = -1;
            fall_cyc[i] = -1;
        end
        done_cnt  = 0;
        done_cyc  = -1;
        fault_cyc = -1;
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < 9; i++) begin
                if (domain_en[i] && !prev[i] && rise_cyc[i] < 0) rise_cyc[i] = cyc;
                if (!domain_en[i] && prev[i] && fall_cyc[i] < 0) fall_cyc[i] = cyc;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (fault === 1'b1 && fault_cyc < 0) fault_cyc = cyc;
            prev = domain_en;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (domain_en !== 9'h1C0) begin bad++; $display("FAIL reset_en got=%h want=1c0", domain_en); end
        total++; if (rq.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", rq.req_ready); end
        total++; if ({busy, done, fault} !== 3'b000) begin bad++; $display("FAIL reset_flags busy/done/fault got=%b want=000", {busy, done, fault}); end
        total++; if (fault_domain !== 4'd0) begin bad++; $display("FAIL reset_fault_domain got=%0d want=0", fault_domain); end
        total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_power_up();
        int ups [5] = '{0, 1, 3, 4, 5};
        send_req(9'h1FB);
        run_watch(5 * STEP + 10);
        for (int k = 0; k < 5; k++) begin
            total++;
            if (rise_cyc[ups[k]] !== acc + 2 + k * STEP) begin
                bad++;
                $display("FAIL up_order bit%0d rose at=%0d want=%0d", ups[k], rise_cyc[ups[k]], acc + 2 + k * STEP);
            end
        end
        total++; if (rise_cyc[2] !== -1) begin bad++; $display("FAIL up_bit2 rose at=%0d want=never", rise_cyc[2]); end
        total++; if (domain_en !== 9'h1FB) begin bad++; $display("FAIL up_final got=%h want=1fb", domain_en); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL up_done_count got=%0d want=1", done_cnt); end
        total++; if (done_cyc !== acc + 1 + 5 * STEP) begin bad++; $display("FAIL up_done_time got=%0d want=%0d", done_cyc, acc + 1 + 5 * STEP); end
    endtask

    task automatic test_power_down();
        send_req(9'h1FF);
        run_watch(STEP + 10);
        total++; if (domain_en !== 9'h1FF) begin bad++; $display("FAIL down_setup got=%h want=1ff", domain_en); end
        send_req(9'h1C0);
        run_watch(6 * (S + 1) + 10);
        for (int k = 0; k < 6; k++) begin
            total++;
            if (fall_cyc[5 - k] !== acc + 2 + k * (S + 1)) begin
                bad++;
                $display("FAIL down_order bit%0d fell at=%0d want=%0d", 5 - k, fall_cyc[5 - k], acc + 2 + k * (S + 1));
            end
        end
        total++; if (done_cyc !== acc + 1 + 6 * (S + 1)) begin bad++; $display("FAIL down_done_time got=%0d want=%0d", done_cyc, acc + 1 + 6 * (S + 1)); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL down_done_count got=%0d want=1", done_cnt); end
        total++; if (domain_en !== 9'h1C0) begin bad++; $display("FAIL down_final got=%h want=1c0", domain_en); end
    endtask

    task automatic test_mangala_rule();
        send_req(9'h004);
        run_watch(S + 10);
        total++; if (fall_cyc[6] !== acc + 2) begin bad++; $display("FAIL mangala_bit6 fell at=%0d want=%0d", fall_cyc[6], acc + 2); end
        total++; if (rise_cyc[2] !== -1) begin bad++; $display("FAIL mangala_bit2 rose at=%0d want=never", rise_cyc[2]); end
        total++; if (domain_en !== 9'h180) begin bad++; $display("FAIL mangala_final got=%h want=180", domain_en); end
        total++; if (done_cyc !== acc + 2 + S) begin bad++; $display("FAIL mangala_done got=%0d want=%0d", done_cyc, acc + 2 + S); end
    endtask

    task automatic test_mixed();
        send_req(9'h1C3);
        run_watch(3 * STEP + 10);
        total++; if (domain_en !== 9'h1C3) begin bad++; $display("FAIL mixed_setup got=%h want=1c3", domain_en); end
        send_req(9'h1C9);
        run_watch(2 * S + 16);
        total++; if (fall_cyc[1] !== acc + 2) begin bad++; $display("FAIL mixed_bit1 fell at=%0d want=%0d", fall_cyc[1], acc + 2); end
        total++; if (rise_cyc[3] !== acc + 3 + S) begin bad++; $display("FAIL mixed_bit3 rose at=%0d want=%0d", rise_cyc[3], acc + 3 + S); end
        total++; if (done_cyc !== acc + 6 + 2 * S) begin bad++; $display("FAIL mixed_done got=%0d want=%0d", done_cyc, acc + 6 + 2 * S); end
        total++; if (domain_en !== 9'h1C9) begin bad++; $display("FAIL mixed_final got=%h want=1c9", domain_en); end
    endtask

    task automatic test_timeout_fault();
        pg_block = 9'h010;
        send_req(9'h1D9);
        run_watch(T + 10);
        total++; if (rise_cyc[4] !== acc + 2) begin bad++; $display("FAIL fault_bit4 rose at=%0d want=%0d", rise_cyc[4], acc + 2); end
        total++; if (fault_cyc !== acc + 2 + T) begin bad++; $display("FAIL fault_time got=%0d want=%0d", fault_cyc, acc + 2 + T); end
        total++; if (fault_domain !== 4'd4) begin bad++; $display("FAIL fault_domain got=%0d want=4", fault_domain); end
        total++; if (domain_en !== 9'h1C9) begin bad++; $display("FAIL fault_en got=%h want=1c9", domain_en); end
        total++; if ({rq.req_ready, busy} !== 2'b00) begin bad++; $display("FAIL fault_ready_busy got=%b want=00", {rq.req_ready, busy}); end
        total++; if (done_cnt !== 0) begin bad++; $display("FAIL fault_done_count got=%0d want=0", done_cnt); end
        @(negedge clk);
        fault_clear = 1'b1;
        @(posedge clk);
        #1;
        fault_clear = 1'b0;
        @(negedge clk);
        total++; if ({rq.req_ready, fault} !== 2'b10) begin bad++; $display("FAIL clear_ready_fault got=%b want=10", {rq.req_ready, fault}); end
        total++; if (fault_domain !== 4'd4) begin bad++; $display("FAIL clear_fault_domain got=%0d want=4", fault_domain); end
        total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL clear_state got=%0d want=0", state_dbg); end
        pg_block = 9'h000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        send_req(9'h1D9);
        @(negedge clk);
        @(negedge clk);
        total++; if ({rq.req_ready, busy} !== 2'b01) begin bad++; $display("FAIL b2b_busy got=%b want=01", {rq.req_ready, busy}); end
        rq.req_valid = 1'b1;
        rq.req_mask  = 9'h1D9;
        @(posedge clk);
        #1;
        rq.req_valid = 1'b0;
        run_watch(STEP + 40);
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL b2b_done_count got=%0d want=1", done_cnt); end
        total++; if (done_cyc !== acc + 1 + STEP) begin bad++; $display("FAIL b2b_done_time got=%0d want=%0d", done_cyc, acc + 1 + STEP); end
        total++; if (domain_en !== 9'h1D9) begin bad++; $display("FAIL b2b_final got=%h want=1d9", domain_en); end
    endtask

    task automatic test_reset_mid_ramp();
        send_req(9'h1FF);
        repeat (10) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midreset_busy got=%b want=1", busy); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (domain_en !== 9'h1C0) begin bad++; $display("FAIL midreset_en got=%h want=1c0", domain_en); end
        total++; if ({rq.req_ready, busy, fault} !== 3'b100) begin bad++; $display("FAIL midreset_flags got=%b want=100", {rq.req_ready, busy, fault}); end
        total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL midreset_state got=%0d want=0", state_dbg); end
    endtask

    initial begin
        rq.req_valid = 1'b0;
        rq.req_mask  = 9'h000;
        fault_clear  = 1'b0;
        test_reset();
        test_power_up();
        test_power_down();
        test_mangala_rule();
        test_mixed();
        test_timeout_fault();
        test_back_to_back();
        test_reset_mid_ramp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
